// File: rtl/led_pattern_if.sv
// Control/status bundle for led_pattern_gen.
// The master drives the run, mode and pattern controls. The slave returns the LED drive and the step pulse.
interface led_pattern_if #(
    parameter int LED_NUM = 4
);
    logic               en;
    logic [1:0]         mode;
    logic               dir;
    logic [LED_NUM-1:0] static_val;
    logic [LED_NUM-1:0] led;
    logic               step;

    modport master (
        output en, mode, dir, static_val,
        input  led, step
    );

    modport slave (
        input  en, mode, dir, static_val,
        output led, step
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver with four modes: static, blink, chase and breathe (PWM triangle).
// A programmable prescaler sets the pattern step rate.
//
// mode         | meaning
// MODE_STATIC  | led follows static_val
// MODE_BLINK   | all on / all off, toggling each tick
// MODE_CHASE   | rotating one-hot, direction from dir
// MODE_BREATHE | PWM with duty ramping up and down each tick
module led_pattern_gen #(
    parameter int LED_NUM  = 4,
    parameter int TICK_DIV = 50000000,
    parameter int PWM_BITS = 8
) (
    input logic           sys_clk,
    input logic           rst_n,
    led_pattern_if.slave  bus
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]    TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [LED_NUM-1:0]  CHASE_INIT = LED_NUM'(1);

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    mode_t               mode_q;
    logic [CNT_W-1:0]    presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                duty_up;
    logic                phase_on;
    logic [LED_NUM-1:0]  chase;
    logic                mode_chg;
    logic                tick;

    // A mode change restarts the step timebase, so the boundary cycle never ticks.
    always_comb begin
        mode_chg = (mode_t'(bus.mode) != mode_q);
        tick     = bus.en && !mode_chg && (presc == TICK_LAST);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_STATIC;
            presc      <= '0;
            pwm_cnt    <= '0;
            duty       <= '0;
            duty_up    <= 1'b1;
            phase_on   <= 1'b1;
            chase      <= CHASE_INIT;
            bus.led    <= '0;
            bus.step   <= 1'b0;
        end else begin
            mode_q   <= mode_t'(bus.mode);
            bus.step <= tick;

            if (mode_chg) begin
                presc    <= '0;
                phase_on <= 1'b1;
                chase    <= CHASE_INIT;
                duty     <= '0;
                duty_up  <= 1'b1;
            end else if (bus.en) begin
                presc <= tick ? '0 : presc + CNT_W'(1);
                if (tick) begin
                    case (mode_q)
                        MODE_BLINK: phase_on <= !phase_on;
                        MODE_CHASE: begin
                            if (bus.dir)
                                chase <= {chase[0], chase[LED_NUM-1:1]};
                            else
                                chase <= {chase[LED_NUM-2:0], chase[LED_NUM-1]};
                        end
                        MODE_BREATHE: begin
                            if (duty_up) begin
                                if (duty == DUTY_MAX) begin
                                    duty_up <= 1'b0;
                                    duty    <= DUTY_MAX - PWM_BITS'(1);
                                end else begin
                                    duty <= duty + PWM_BITS'(1);
                                end
                            end else begin
                                if (duty == '0) begin
                                    duty_up <= 1'b1;
                                    duty    <= PWM_BITS'(1);
                                end else begin
                                    duty <= duty - PWM_BITS'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // LED drive is one register behind the pattern state and freezes with en.
            if (bus.en) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                case (mode_q)
                    MODE_STATIC:  bus.led <= bus.static_val;
                    MODE_BLINK:   bus.led <= phase_on ? '1 : '0;
                    MODE_CHASE:   bus.led <= chase;
                    MODE_BREATHE: bus.led <= {LED_NUM{pwm_cnt < duty}};
                    default:      bus.led <= '0;
                endcase
            end
        end
    end
endmodule
